// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling.
// Contains the input synchroniser, the baud enable generator, the receive FSM and the output register.
module uart_rx #(
   parameter int BAUD_RATE  = 9_600,
   parameter int CLOCK_RATE = 40_000_000
) (
   input  logic       clk_rx,
   input  logic       rst_clk_rx,
   input  logic       rxd_i,
   output logic [7:0] rx_data,
   output logic       rx_data_rdy,
   output logic       frm_err
);

   // Rounded divide. DIV must be at least 2.
   localparam int DIV = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   logic [1:0]    sync_q;
   logic          rxd_s;
   logic [CW-1:0] cnt_q;
   logic          baud_en;

   state_t        state_q, state_d;
   logic [3:0]    over_q, over_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sr_q, sr_d;
   logic [7:0]    data_q, data_d;
   logic          rdy_q, rdy_d;
   logic          err_q, err_d;

   assign rxd_s   = sync_q[1];
   assign baud_en = (cnt_q == CW'(DIV - 1));

   always_ff @(posedge clk_rx) begin
      if (rst_clk_rx) begin
         sync_q <= 2'b11;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], rxd_i};
         cnt_q  <= baud_en ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_rx) begin
      if (rst_clk_rx) begin
         state_q <= IDLE;
         over_q  <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         over_q  <= over_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      over_d  = over_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      data_d  = data_q;
      rdy_d   = 1'b0;
      err_d   = 1'b0;
      if (baud_en) begin
         case (state_q)
            IDLE: begin
               if (!rxd_s) begin
                  state_d = START;
                  over_d  = '0;
               end
            end
            START: begin
               // Recheck the line at mid start bit to reject glitches.
               if (over_q == 4'd7) begin
                  if (!rxd_s) begin
                     state_d = DATA;
                     over_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  over_d = over_q + 4'd1;
               end
            end
            DATA: begin
               over_d = over_q + 4'd1;
               if (over_q == 4'd15) begin
                  sr_d = {rxd_s, sr_q[7:1]};
                  if (bit_q == 3'd7) state_d = STOP;
                  else               bit_d   = bit_q + 3'd1;
               end
            end
            STOP: begin
               over_d = over_q + 4'd1;
               if (over_q == 4'd15) begin
                  if (rxd_s) begin
                     data_d  = sr_q;
                     rdy_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = BREAK;
                  end
               end
            end
            BREAK: begin
               // Stay here while the line is low so that a held-low line gives a single error.
               if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign rx_data     = data_q;
   assign rx_data_rdy = rdy_q;
   assign frm_err     = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at DIV = 10 (160 clocks per bit).
// Each expected strobe is queued when its frame is driven and is checked by the strobe monitor.
module tb_uart_rx;

   typedef struct {
      bit         err;
      logic [7:0] data;
   } exp_t;

   logic       clk_rx = 1'b0;
   logic       rst_clk_rx = 1'b1;
   logic       rxd_i = 1'b1;
   logic [7:0] rx_data;
   logic       rx_data_rdy;
   logic       frm_err;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   rdy_cnt = 0;
   int   err_cnt = 0;
   int   last_rdy_cyc = 0;
   int   prev_rdy_cyc = 0;
   exp_t sb[$];

   uart_rx #(.BAUD_RATE(10_000), .CLOCK_RATE(1_600_000)) dut (
      .clk_rx      (clk_rx),
      .rst_clk_rx  (rst_clk_rx),
      .rxd_i       (rxd_i),
      .rx_data     (rx_data),
      .rx_data_rdy (rx_data_rdy),
      .frm_err     (frm_err)
   );

   always #5 clk_rx = ~clk_rx;
   always @(posedge clk_rx) cyc <= cyc + 1;

   // Strobe monitor: pops the scoreboard and checks the pulse invariants.
   logic       prev_rdy = 1'b0, prev_err = 1'b0, prev_rst = 1'b1;
   logic [7:0] prev_data = 8'h00, last_good = 8'h00;
   always @(negedge clk_rx) begin
      exp_t e;
      if (rx_data_rdy || frm_err) begin
         total++;
         if (rx_data_rdy && frm_err) begin
            bad++; $display("FAIL both_strobes: rdy=%b err=%b, required not both high", rx_data_rdy, frm_err);
         end
         total++;
         if ((rx_data_rdy && prev_rdy) || (frm_err && prev_err)) begin
            bad++; $display("FAIL pulse_width: strobe high on two cycles, required one cycle at cyc=%0d", cyc);
         end
      end
      if (rx_data_rdy) begin
         rdy_cnt++;
         prev_rdy_cyc = last_rdy_cyc;
         last_rdy_cyc = cyc;
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL unexpected_rdy: data=%h, required no strobe", rx_data);
         end else begin
            e = sb.pop_front();
            if (e.err || rx_data !== e.data) begin
               bad++; $display("FAIL rdy_data: got rdy data=%h, required err=%0d data=%h", rx_data, e.err, e.data);
            end
         end
         last_good = rx_data;
      end
      if (frm_err) begin
         err_cnt++;
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL unexpected_err: frm_err high, required no strobe");
         end else begin
            e = sb.pop_front();
            if (!e.err) begin
               bad++; $display("FAIL err_kind: got frm_err, required rdy with data=%h", e.data);
            end
         end
         total++;
         if (rx_data !== last_good) begin
            bad++; $display("FAIL err_data_hold: rx_data=%h, required %h", rx_data, last_good);
         end
      end
      if (prev_rst) last_good = 8'h00;
      if (rx_data !== prev_data && !rx_data_rdy && !prev_rst) begin
         total++; bad++;
         $display("FAIL data_change: rx_data %h->%h without rdy", prev_data, rx_data);
      end
      prev_rst  = rst_clk_rx;
      prev_rdy  = rx_data_rdy;
      prev_err  = frm_err;
      prev_data = rx_data;
   end

   task automatic drive_bit(input logic v, input int n);
      rxd_i = v;
      repeat (n) @(posedge clk_rx);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input int bl, input logic stop_v);
      drive_bit(1'b0, bl);
      for (int i = 0; i < 8; i++) drive_bit(b[i], bl);
      drive_bit(stop_v, bl);
   endtask

   task automatic push(input bit err, input logic [7:0] d);
      exp_t e;
      e.err  = err;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic check_counts(input string name, input int rdy_exp, input int err_exp);
      total++;
      if (rdy_cnt !== rdy_exp || err_cnt !== err_exp || sb.size() != 0) begin
         bad++;
         $display("FAIL %s: rdy=%0d err=%0d pending=%0d, required rdy=%0d err=%0d pending=0",
                  name, rdy_cnt, err_cnt, sb.size(), rdy_exp, err_exp);
      end
   endtask

   task automatic test_reset;
      rst_clk_rx = 1'b1;
      repeat (5) @(posedge clk_rx);
      #1;
      total++;
      if (rx_data !== 8'h00 || rx_data_rdy !== 1'b0 || frm_err !== 1'b0) begin
         bad++; $display("FAIL reset_vals: %h/%b/%b, required 00/0/0", rx_data, rx_data_rdy, frm_err);
      end
      rst_clk_rx = 1'b0;
      drive_bit(1'b1, 50);
   endtask

   task automatic test_single;
      int t0, fall;
      int r0 = rdy_cnt, e0 = err_cnt;
      push(0, 8'h55);
      t0 = cyc;
      send_frame(8'h55, 160, 1'b1);
      drive_bit(1'b1, 200);
      check_counts("single_55", r0 + 1, e0);
      fall = last_rdy_cyc + 1 - t0;
      total++;
      if (fall < 1520 || fall > 1533) begin
         bad++; $display("FAIL latency: rdy falls %0d clocks after start, required 1520..1533", fall);
      end
   endtask

   task automatic test_back_to_back;
      int r0 = rdy_cnt, e0 = err_cnt;
      push(0, 8'hA5);
      push(0, 8'h3C);
      send_frame(8'hA5, 160, 1'b1);
      send_frame(8'h3C, 160, 1'b1);
      drive_bit(1'b1, 200);
      check_counts("back_to_back", r0 + 2, e0);
      total++;
      if (last_rdy_cyc - prev_rdy_cyc != 1600) begin
         bad++; $display("FAIL b2b_spacing: %0d clocks, required 1600", last_rdy_cyc - prev_rdy_cyc);
      end
   endtask

   task automatic test_glitch;
      int r0 = rdy_cnt, e0 = err_cnt;
      drive_bit(1'b0, 40);
      drive_bit(1'b1, 400);
      check_counts("glitch_quiet", r0, e0);
      push(0, 8'h0F);
      send_frame(8'h0F, 160, 1'b1);
      drive_bit(1'b1, 200);
      check_counts("after_glitch", r0 + 1, e0);
   endtask

   task automatic test_break;
      int r0 = rdy_cnt, e0 = err_cnt;
      push(0, 8'h12);
      send_frame(8'h12, 160, 1'b1);
      drive_bit(1'b1, 200);
      push(1, 8'h00);
      send_frame(8'hF0, 160, 1'b0);
      drive_bit(1'b0, 800);
      drive_bit(1'b1, 300);
      check_counts("break_err", r0 + 1, e0 + 1);
      total++;
      if (rx_data !== 8'h12) begin
         bad++; $display("FAIL break_hold: rx_data=%h, required 12", rx_data);
      end
      push(0, 8'h81);
      send_frame(8'h81, 160, 1'b1);
      drive_bit(1'b1, 200);
      check_counts("after_break", r0 + 2, e0 + 1);
   endtask

   task automatic test_mid_reset;
      logic [7:0] b = 8'h7E;
      int r0 = rdy_cnt, e0 = err_cnt;
      drive_bit(1'b0, 160);
      for (int i = 0; i < 4; i++) drive_bit(b[i], 160);
      drive_bit(b[4], 80);
      rst_clk_rx = 1'b1;
      @(posedge clk_rx);
      #1;
      rst_clk_rx = 1'b0;
      total++;
      if (rx_data !== 8'h00 || rx_data_rdy !== 1'b0 || frm_err !== 1'b0) begin
         bad++; $display("FAIL mid_reset_vals: %h/%b/%b, required 00/0/0", rx_data, rx_data_rdy, frm_err);
      end
      drive_bit(1'b1, 2000);
      check_counts("aborted_frame", r0, e0);
      push(0, 8'h7E);
      send_frame(8'h7E, 160, 1'b1);
      drive_bit(1'b1, 200);
      check_counts("after_reset", r0 + 1, e0);
   endtask

   task automatic test_tolerance;
      int r0 = rdy_cnt, e0 = err_cnt;
      push(0, 8'hC3);
      send_frame(8'hC3, 152, 1'b1);
      drive_bit(1'b1, 300);
      check_counts("fast_5pct", r0 + 1, e0);
      push(0, 8'hC3);
      send_frame(8'hC3, 168, 1'b1);
      drive_bit(1'b1, 300);
      check_counts("slow_5pct", r0 + 2, e0);
      total++;
      if (rx_data !== 8'hC3) begin
         bad++; $display("FAIL tol_data: rx_data=%h, required c3", rx_data);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_break();
      test_mid_reset();
      test_tolerance();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
